// File: rtl/uart_cmd_bridge_if.sv
// Byte-stream and peripheral-bus signals of the UART command bridge.
// The master modport is the bridge; the slave modport is the UART pair plus the bus.
interface uart_cmd_bridge_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [7:0]            rx_byte_i;
  logic                  rx_valid_i;
  logic [7:0]            tx_byte_o;
  logic                  tx_valid_o;
  logic                  tx_ready_i;
  logic                  ren_o;
  logic                  we_o;
  logic [ADDR_WIDTH-1:0] addr_o;
  logic [31:0]           wdata_o;
  logic [31:0]           rdata_i;
  logic                  busy_o;
  logic                  err_o;

  modport master (
    input  rx_byte_i, rx_valid_i, tx_ready_i, rdata_i,
    output tx_byte_o, tx_valid_o, ren_o, we_o, addr_o, wdata_o, busy_o, err_o
  );

  modport slave (
    output rx_byte_i, rx_valid_i, tx_ready_i, rdata_i,
    input  tx_byte_o, tx_valid_o, ren_o, we_o, addr_o, wdata_o, busy_o, err_o
  );
endinterface

// File: rtl/uart_cmd_bridge.sv
// Decodes 'W'/'R' command frames from a UART byte stream into single-cycle
// peripheral bus accesses and streams the response bytes back out.
module uart_cmd_bridge #(
  parameter int          ADDR_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input logic               clk_i,
  input logic               rst_ni,
  uart_cmd_bridge_if.master bus
);
  localparam logic [7:0]  OP_WR        = 8'h57;
  localparam logic [7:0]  OP_RD        = 8'h52;
  localparam logic [7:0]  RSP_OK       = 8'h4B;
  localparam logic [7:0]  RSP_ERR      = 8'h45;
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, BUS_WR, BUS_RD, SEND} state_e;

  state_e      state_q;
  logic        is_wr_q;
  logic [1:0]  byte_cnt_q;
  logic [31:0] timeout_cnt_q;
  logic [31:0] shift_q;
  logic [1:0]  send_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      is_wr_q        <= 1'b0;
      byte_cnt_q     <= 2'd0;
      timeout_cnt_q  <= 32'd0;
      shift_q        <= 32'd0;
      send_cnt_q     <= 2'd0;
      bus.tx_byte_o  <= 8'd0;
      bus.tx_valid_o <= 1'b0;
      bus.ren_o      <= 1'b0;
      bus.we_o       <= 1'b0;
      bus.addr_o     <= '0;
      bus.wdata_o    <= 32'd0;
      bus.busy_o     <= 1'b0;
      bus.err_o      <= 1'b0;
    end else begin
      bus.ren_o <= 1'b0;
      bus.we_o  <= 1'b0;
      bus.err_o <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.rx_valid_i) begin
            if (bus.rx_byte_i == OP_WR || bus.rx_byte_i == OP_RD) begin
              is_wr_q       <= (bus.rx_byte_i == OP_WR);
              timeout_cnt_q <= 32'd0;
              state_q       <= GET_ADDR;
            end else begin
              bus.err_o      <= 1'b1;
              bus.tx_byte_o  <= RSP_ERR;
              bus.tx_valid_o <= 1'b1;
              send_cnt_q     <= 2'd0;
              state_q        <= SEND;
            end
            bus.busy_o <= 1'b1;
          end
        end
        GET_ADDR, GET_DATA: begin
          // An arriving byte wins over a simultaneous timeout expiry.
          if (bus.rx_valid_i) begin
            timeout_cnt_q <= 32'd0;
            if (state_q == GET_ADDR) begin
              bus.addr_o <= ADDR_WIDTH'(bus.rx_byte_i);
              if (is_wr_q) begin
                byte_cnt_q <= 2'd0;
                state_q    <= GET_DATA;
              end else begin
                bus.ren_o <= 1'b1;
                state_q   <= BUS_RD;
              end
            end else begin
              bus.wdata_o[{byte_cnt_q, 3'b000} +: 8] <= bus.rx_byte_i;
              byte_cnt_q <= byte_cnt_q + 2'd1;
              if (byte_cnt_q == 2'd3) begin
                bus.we_o <= 1'b1;
                state_q  <= BUS_WR;
              end
            end
          end else if (timeout_cnt_q == TIMEOUT_LAST) begin
            bus.err_o     <= 1'b1;
            timeout_cnt_q <= 32'd0;
            bus.busy_o    <= 1'b0;
            state_q       <= IDLE;
          end else begin
            timeout_cnt_q <= timeout_cnt_q + 32'd1;
          end
        end
        BUS_WR: begin
          bus.err_o      <= bus.rx_valid_i;
          bus.tx_byte_o  <= RSP_OK;
          bus.tx_valid_o <= 1'b1;
          send_cnt_q     <= 2'd0;
          state_q        <= SEND;
        end
        BUS_RD: begin
          // Read data is captured once here; the peripheral may pop on read.
          bus.err_o      <= bus.rx_valid_i;
          shift_q        <= bus.rdata_i;
          bus.tx_byte_o  <= bus.rdata_i[7:0];
          bus.tx_valid_o <= 1'b1;
          send_cnt_q     <= 2'd3;
          state_q        <= SEND;
        end
        SEND: begin
          bus.err_o <= bus.rx_valid_i;
          if (bus.tx_valid_o && bus.tx_ready_i) begin
            if (send_cnt_q == 2'd0) begin
              bus.tx_valid_o <= 1'b0;
              bus.busy_o     <= 1'b0;
              state_q        <= IDLE;
            end else begin
              bus.tx_byte_o <= shift_q[15:8];
              shift_q       <= {8'd0, shift_q[31:8]};
              send_cnt_q    <= send_cnt_q - 2'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Directed bench for uart_cmd_bridge: write/read frames, stalls, bad opcode,
// inter-byte timeout and mid-frame reset.
module tb_uart_cmd_bridge;
  localparam int AW = 8;
  localparam int TO = 16;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  uart_cmd_bridge_if #(.ADDR_WIDTH(AW)) bus ();

  uart_cmd_bridge #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  // Peripheral register file seen through the bus
  always_comb begin
    case (bus.addr_o)
      8'h08:   bus.rdata_i = 32'hA1B2C3D4;
      8'h10:   bus.rdata_i = 32'h0BADF00D;
      default: bus.rdata_i = 32'hDEADBEEF;
    endcase
  end

  int         we_cnt = 0;
  int         ren_cnt = 0;
  logic [7:0] tx_q[$];
  always @(posedge clk_i) begin
    if (bus.we_o) we_cnt <= we_cnt + 1;
    if (bus.ren_o) ren_cnt <= ren_cnt + 1;
    if (bus.tx_valid_o && bus.tx_ready_i) tx_q.push_back(bus.tx_byte_o);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Returns 1 ns after the edge that samples the byte (end of strobe cycle N).
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_i);
    bus.rx_byte_i  = b;
    bus.rx_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    bus.rx_valid_i = 1'b0;
  endtask

  task automatic send_write(input logic [7:0] a, input logic [31:0] d, input int gap);
    send_byte(8'h57); tick(gap);
    send_byte(a);     tick(gap);
    send_byte(d[7:0]);   tick(gap);
    send_byte(d[15:8]);  tick(gap);
    send_byte(d[23:16]); tick(gap);
    send_byte(d[31:24]);
  endtask

  int         we0, ren0, q0, n;
  logic       stable;
  logic [7:0] rd_exp[4];

  initial begin
    bus.rx_byte_i  = 8'd0;
    bus.rx_valid_i = 1'b0;
    bus.tx_ready_i = 1'b1;
    tick(3);
    check("reset_outs", {bus.tx_byte_o, bus.tx_valid_o, bus.ren_o, bus.we_o, bus.addr_o,
                         bus.wdata_o, bus.busy_o, bus.err_o}, 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick(2);

    // Write frame, 10-cycle gaps
    we0 = we_cnt; q0 = tx_q.size();
    send_write(8'h2C, 32'h12345678, 9);
    check("wr_we_n1", bus.we_o, 1);
    check("wr_addr", bus.addr_o, 8'h2C);
    check("wr_data", bus.wdata_o, 32'h12345678);
    tick(1);
    check("wr_we_n2", bus.we_o, 0);
    check("wr_txv_n2", {bus.tx_valid_o, bus.tx_byte_o}, {1'b1, 8'h4B});
    tick(1);
    check("wr_done", {bus.tx_valid_o, bus.busy_o}, 2'b00);
    check("wr_we_count", we_cnt - we0, 1);
    check("wr_tx_count", tx_q.size() - q0, 1);

    // Read frame, ready always high
    ren0 = ren_cnt;
    rd_exp[0] = 8'hD4; rd_exp[1] = 8'hC3; rd_exp[2] = 8'hB2; rd_exp[3] = 8'hA1;
    send_byte(8'h52); tick(9);
    send_byte(8'h08);
    check("rd_ren_n1", {bus.ren_o, bus.addr_o}, {1'b1, 8'h08});
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check($sformatf("rd_byte%0d", i), {bus.tx_valid_o, bus.tx_byte_o}, {1'b1, rd_exp[i]});
    end
    tick(1);
    check("rd_done", {bus.tx_valid_o, bus.busy_o}, 2'b00);
    check("rd_ren_count", ren_cnt - ren0, 1);

    // Same read with the transmitter stalled 20 cycles per byte
    ren0 = ren_cnt; q0 = tx_q.size();
    bus.tx_ready_i = 1'b0;
    send_byte(8'h52); tick(2);
    send_byte(8'h08);
    tick(1);
    send_byte(8'h99);
    check("drop_err", {bus.err_o, bus.tx_valid_o, bus.tx_byte_o}, {1'b1, 1'b1, 8'hD4});
    for (int i = 0; i < 4; i++) begin
      stable = 1'b1;
      for (int k = 0; k < 20; k++) begin
        tick(1);
        if (!bus.tx_valid_o || bus.tx_byte_o !== rd_exp[i]) stable = 1'b0;
      end
      check($sformatf("stall_hold%0d", i), stable, 1);
      @(negedge clk_i);
      bus.tx_ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      bus.tx_ready_i = 1'b0;
    end
    tick(1);
    check("stall_done", bus.tx_valid_o, 0);
    check("stall_count", tx_q.size() - q0, 4);
    check("stall_bytes", {tx_q[q0], tx_q[q0+1], tx_q[q0+2], tx_q[q0+3]}, 32'hD4C3B2A1);
    check("stall_ren", ren_cnt - ren0, 1);
    bus.tx_ready_i = 1'b1;
    tick(2);

    // Bad opcode, then a normal write
    we0 = we_cnt; ren0 = ren_cnt;
    send_byte(8'h33);
    check("bad_err", {bus.err_o, bus.tx_valid_o, bus.tx_byte_o}, {1'b1, 1'b1, 8'h45});
    tick(1);
    check("bad_clear", {bus.err_o, bus.tx_valid_o, bus.busy_o}, 3'b000);
    check("bad_no_bus", {we_cnt - we0, ren_cnt - ren0}, 64'd0);
    send_write(8'h20, 32'hDEADBEEF, 1);
    check("post_bad_wr", {bus.we_o, bus.addr_o, bus.wdata_o}, {1'b1, 8'h20, 32'hDEADBEEF});
    tick(1);
    check("post_bad_k", {bus.tx_valid_o, bus.tx_byte_o}, {1'b1, 8'h4B});
    tick(2);

    // Inter-byte timeout
    we0 = we_cnt; q0 = tx_q.size();
    send_byte(8'h57); tick(1);
    send_byte(8'h10); tick(1);
    send_byte(8'hAA);
    n = 0;
    while (n < 40) begin
      tick(1);
      n++;
      if (bus.err_o) break;
    end
    check("to_cycles", n, TO);
    tick(1);
    check("to_idle", {bus.busy_o, bus.tx_valid_o, bus.err_o}, 3'b000);
    check("to_no_we", we_cnt - we0, 0);
    check("to_no_tx", tx_q.size() - q0, 0);
    ren0 = ren_cnt;
    send_byte(8'h52); tick(1);
    send_byte(8'h10);
    tick(5);
    check("to_rd_bytes", {tx_q[q0], tx_q[q0+1], tx_q[q0+2], tx_q[q0+3]}, 32'h0DF0AD0B);
    check("to_rd_ren", ren_cnt - ren0, 1);
    tick(2);

    // Reset in the middle of a write frame
    we0 = we_cnt;
    send_byte(8'h57); tick(1);
    send_byte(8'h30); tick(1);
    send_byte(8'h11);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check("rst_mid_outs", {bus.tx_byte_o, bus.tx_valid_o, bus.ren_o, bus.we_o, bus.addr_o,
                           bus.wdata_o, bus.busy_o, bus.err_o}, 64'd0);
    tick(2);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick(3);
    check("rst_no_we", we_cnt - we0, 0);
    send_write(8'h30, 32'h11223344, 2);
    check("rst_fresh_wr", {bus.we_o, bus.addr_o, bus.wdata_o}, {1'b1, 8'h30, 32'h11223344});
    tick(1);
    check("rst_fresh_k", {bus.tx_valid_o, bus.tx_byte_o}, {1'b1, 8'h4B});
    tick(2);
    check("rst_fresh_idle", bus.busy_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_cmd_bridge.md
Name: uart_cmd_bridge

Overview:
- Serial-side command responder that sits behind a uart_rx/uart_tx pair. It gives an external host register-level access to the 8-bit-address/32-bit-data peripheral bus (ren/we/addr/wdata/rdata) used by uart_core and sibling peripherals.
- It decodes framed read/write commands from the received byte stream, issues single-cycle bus accesses, and returns response bytes through a valid/ready transmit handshake.

Parameters:
- ADDR_WIDTH, 8, bus address width; the address is always one frame byte, zero-extended or truncated to ADDR_WIDTH.
- TIMEOUT_CYCLES, 100000, max idle clk_i cycles between bytes of one frame before abort; 32-bit counter; minimum 2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- rx_byte_i  in  8  received byte, valid only with rx_valid_i
- rx_valid_i  in  1  one-cycle strobe per received byte (uart_rx o_Rx_DV style)
- tx_byte_o  out  8  response byte to transmitter
- tx_valid_o  out  1  tx_byte_o valid; held until accepted
- tx_ready_i  in  1  transmitter accepts byte when tx_valid_o & tx_ready_i
- ren_o  out  1  bus read strobe, one cycle
- we_o  out  1  bus write strobe, one cycle
- addr_o  out  ADDR_WIDTH  bus address
- wdata_o  out  32  bus write data
- rdata_i  in  32  bus read data, combinational from addr_o; sampled in the ren_o cycle
- busy_o  out  1  high in any state except IDLE
- err_o  out  1  one-cycle pulse on protocol error

Behaviour:
- Reset is asynchronous, active-low, on rst_ni; clock is clk_i, rising edge. All outputs are registered.
- Reset values: tx_byte_o=0, tx_valid_o=0, ren_o=0, we_o=0, addr_o=0, wdata_o=0, busy_o=0, err_o=0. State=IDLE, byte counter=0, timeout counter=0.
- Frames:
  - Write: 8'h57 ('W'), addr, d[7:0], d[15:8], d[23:16], d[31:24].
  - Read: 8'h52 ('R'), addr.
- Responses:
  - Write: 8'h4B ('K').
  - Read: 4 bytes of rdata, LSB first.
  - Bad opcode: 8'h45 ('E').
- States: IDLE, GET_ADDR, GET_DATA, BUS_WR, BUS_RD, SEND.
- IDLE:
  - On rx_valid_i with 'W' or 'R', latch the opcode and go to GET_ADDR.
  - Any other byte: err_o pulse next cycle, load 'E' into SEND.
- GET_ADDR:
  - On rx_valid_i, latch addr.
  - If 'R', go to BUS_RD.
  - If 'W', clear the byte counter and go to GET_DATA.
- GET_DATA: each rx_valid_i writes wdata byte lane[counter] and increments the 2-bit counter. The byte with counter==3 goes to BUS_WR.
- BUS_WR: we_o=1 for exactly one cycle with stable addr_o/wdata_o. Next cycle, load 'K' into SEND.
- BUS_RD: ren_o=1 for exactly one cycle; rdata_i is captured into the response shift register on that edge. ren_o is never asserted more than once per frame, because FIFO-backed registers pop on read. Then go to SEND with 4 bytes pending.
- SEND:
  - tx_valid_o=1 with the current byte. On tx_valid_o & tx_ready_i, shift to the next byte in the following cycle; there is no bubble required beyond one cycle.
  - After the last byte is accepted, tx_valid_o=0 and the state returns to IDLE.
  - tx_byte_o is stable while tx_valid_o & ~tx_ready_i.
- Latency: last frame byte strobe at cycle N gives we_o/ren_o high in N+1 and tx_valid_o high in N+2.
- Timeout:
  - The counter runs only in GET_ADDR/GET_DATA and clears on every rx_valid_i.
  - When the count reaches TIMEOUT_CYCLES: err_o pulse, return to IDLE, no bus access, no response.
  - rx_valid_i in the same cycle as expiry takes priority (byte accepted, no error).
- rx_valid_i in BUS_WR, BUS_RD or SEND: byte dropped, err_o pulse, current transaction continues unaffected.
- An error and the acceptance of a new opcode never occur in the same cycle, because the state is not IDLE when dropping.
- Reset mid-frame or mid-SEND: everything returns to reset values immediately; partial frame discarded; no bus strobe is generated.

Test Plan:
- Write frame 57 2C 78 56 34 12, bytes 10 cycles apart, tx_ready_i=1 -> one we_o pulse with addr_o=8'h2C, wdata_o=32'h12345678; tx_byte_o=8'h4B with tx_valid_o at N+2; busy_o low afterwards.
- Read frame 52 08 with rdata_i=32'hA1B2C3D4 at addr 8'h08 -> exactly one ren_o pulse; response bytes D4, C3, B2, A1 in order.
- Same read with tx_ready_i held low 20 cycles per byte -> tx_byte_o stable while stalled; no byte lost or duplicated.
- Opcode 8'h33 -> err_o pulse, response 8'h45, no ren_o/we_o; a following valid write frame completes normally.
- TIMEOUT_CYCLES=16; send 57 10 AA then stop -> err_o after 16 idle cycles, no we_o, no response; then 52 10 -> normal read.
- rst_ni low after 3 bytes of a write frame, then released -> outputs at reset values, no we_o; a fresh frame succeeds.
